limits_reader: RTL and testbench
================================

# limits_reader

Streaming reader for the limits buffer. On a start command it fetches `ctrl_count` consecutive 32-bit words from the buffer's read port, starting at `ctrl_base`. It delivers them in order on a ready/valid stream to the reconstruction datapath. A small prefetch FIFO hides the two-cycle RAM read latency and absorbs sink backpressure, so the stream sustains one word per clock while the sink is ready. The block sits between the read port (port B) of the limits buffer and the reconstruction core; HPS writes the buffer contents through port A.

## Interface
- `ADDR_W`, 8: buffer word-address width; the buffer holds 2^ADDR_W words.
- `DATA_W`, 32: word width.
- `READ_LATENCY`, 2: cycles from a read being issued to its data being valid on `buf_readdata` (registered address plus registered output).
- `FIFO_DEPTH`, 4: prefetch FIFO depth; must be >= READ_LATENCY+1.

Ports:
- `clock` in 1: the only clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `ctrl_start` in 1: single-cycle request to start a run.
- `ctrl_base` in ADDR_W: first word address, latched at start.
- `ctrl_count` in ADDR_W+1: number of words to read (0..2^ADDR_W), latched at start.
- `ctrl_busy` out 1: high while a run is active.
- `ctrl_done` out 1: one-cycle pulse when a run ends.
- `buf_address` out ADDR_W: read address to the buffer port B.
- `buf_chipselect` out 1: high whenever `buf_read` is high.
- `buf_read` out 1: read strobe, one word per high cycle.
- `buf_readdata` in DATA_W: read data, valid READ_LATENCY cycles after the strobe.
- `st_data` out DATA_W: stream data.
- `st_valid` out 1: stream valid.
- `st_ready` in 1: stream ready from the sink.
- `st_last` out 1: marks the last word of the run; qualified by `st_valid`.

## Operation
- The state machine has three states:
  - IDLE: `ctrl_start` latches base and count, zeroes the issue and delivery counters, and moves to FETCH. If the latched count is 0, the block stays in IDLE and pulses `ctrl_done` on the next cycle.
  - FETCH: the block issues reads until the issued count equals the latched count, then moves to DRAIN.
  - DRAIN: the block waits until the last word has been accepted, pulses `ctrl_done`, and returns to IDLE.
- Issue rule: a read is issued in a cycle when issued < count and (in-flight reads + FIFO occupancy) < FIFO_DEPTH. This credit scheme guarantees the FIFO never overflows.
- Addressing: `buf_address` = base + issued, computed modulo 2^ADDR_W. Wrap-around from 255 to 0 is legal.
- In-flight tracking: a READ_LATENCY-deep valid shift register. When its output bit is high, `buf_readdata` is written into the FIFO.
- Stream output: `st_valid` is high when the FIFO is not empty, and `st_data` is the FIFO head. A word is popped when `st_valid && st_ready`.
  - `st_data` must hold stable while `st_valid` is high and `st_ready` is low.
  - The block never withdraws `st_valid` once it is asserted.
- `st_last` is high when the FIFO head is delivered word number count-1.
- `ctrl_start` while `ctrl_busy` is high is ignored, and no state changes.
- `ctrl_busy` is high from the cycle after start is accepted until the cycle of the `ctrl_done` pulse (inclusive).
- Reset, including reset mid-run:
  - The FSM returns to IDLE, the FIFO is flushed and in-flight reads are discarded.
  - All outputs are 0 (`buf_address` = 0, `st_data` = 0).
  - Late `buf_readdata` arriving after reset is ignored.

## Timing
- Edge E0 samples `ctrl_start`.
- `buf_read` is registered and goes high after E0.
- The RAM registers the address at E1; its output register updates at E2.
- The FIFO writes at E3; `st_valid` is high after E3. First-word latency is 3 edges.
- With `st_ready` held high, `buf_read` stays high for count consecutive cycles and `st_valid` stays high for count consecutive cycles.
- `ctrl_done` pulses the cycle after the handshake of the `st_last` word.
- Backpressure: when `st_ready` drops, issue stops after at most FIFO_DEPTH outstanding-plus-stored words. When `st_ready` returns, issue resumes in the next cycle.
- Simultaneous FIFO push and pop in one cycle are both honoured; occupancy is unchanged.

## Configuration
- Macro: `LIMITS_READER_LOOP_EN`.
- Defined:
  - An extra input port `ctrl_stop` (1 bit) exists.
  - After word count-1 is issued, the issue address reloads to base and fetching continues without a bubble.
  - `st_last` and `ctrl_done` fire once per pass.
  - A `ctrl_stop` pulse is latched; the run ends at the end of the current pass and the block enters DRAIN.
  - A count of 0 ends the run immediately, as in single-pass mode.
- Undefined: the block runs a single pass only, and the `ctrl_stop` port is absent.

## Test plan
- Reset, then start with base=0x10, count=4, RAM[0x10..0x13]=A0..A3, `st_ready`=1:
  - `buf_read` is high for 4 cycles and the stream carries A0..A3 on 4 consecutive cycles.
  - First `st_valid` comes 3 edges after start; `st_last` is set on A3; `ctrl_done` pulses 1 cycle later.
- Base=0xFE, count=4 -> addresses FE, FF, 00, 01 in order; the data matches.
- Count=256, `st_ready` random at 50% -> all 256 words are delivered in order with no loss or duplication, and the credit count never exceeds 4.
- Count=0 -> no `buf_read`, `ctrl_done` pulses one cycle after start, `ctrl_busy` pulses for that same single cycle, and no `st_valid`.
- `ctrl_start` pulsed again mid-run with a different base -> ignored; the original run completes unchanged.
- `reset_n` asserted while 2 reads are in flight and the FIFO holds 2 words -> all outputs are 0 immediately. After release, a new run with count=1 delivers exactly one correct word.

Source files
------------

// File: rtl/limits_reader.sv
// limits_reader: fetches ctrl_count consecutive words from the limits buffer read port,
// starting at ctrl_base, and streams them out on a ready/valid interface. A small
// prefetch FIFO hides the RAM read latency and absorbs sink backpressure.
// Optional feature macro: LIMITS_READER_LOOP_EN (continuous looping with ctrl_stop).
module limits_reader #(
  parameter int unsigned ADDR_W       = 8,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              ctrl_start,
  input  logic [ADDR_W-1:0] ctrl_base,
  input  logic [ADDR_W:0]   ctrl_count,
`ifdef LIMITS_READER_LOOP_EN
  input  logic              ctrl_stop,
`endif
  output logic              ctrl_busy,
  output logic              ctrl_done,
  output logic [ADDR_W-1:0] buf_address,
  output logic              buf_chipselect,
  output logic              buf_read,
  input  logic [DATA_W-1:0] buf_readdata,
  output logic [DATA_W-1:0] st_data,
  output logic              st_valid,
  input  logic              st_ready,
  output logic              st_last
);

  localparam int unsigned CntW = ADDR_W + 1;
  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned OccW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned CrW  = $clog2(FIFO_DEPTH + READ_LATENCY + 2);

  typedef enum logic [1:0] {StIdle, StFetch, StDrain} state_e;

  state_e state_q, state_d;

  logic [ADDR_W-1:0]       base_q, base_d;
  logic [CntW-1:0]         count_q, count_d;
  logic [CntW-1:0]         issued_q, issued_d;
  logic [CntW-1:0]         deliv_q, deliv_d;
  logic                    rd_q, rd_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [READ_LATENCY-1:0] inflight_q;
  logic                    done_q, done_d;

  logic [DATA_W-1:0]       fifo_mem [FIFO_DEPTH];
  logic [PtrW-1:0]         wptr_q, rptr_q;
  logic [OccW-1:0]         occ_q;

  logic                    start_acc;
  logic                    busy;
  logic                    fifo_push;
  logic                    fifo_pop;
  logic                    fifo_nonempty;
  logic                    head_last;
  logic [CrW-1:0]          credit;
  logic                    room;
  logic                    drain_exit;
  logic                    stop_now;
  logic                    in_run;
  logic [ADDR_W-1:0]       eff_base;
  logic [CntW-1:0]         eff_count;
  logic [CntW-1:0]         eff_issued;

`ifdef LIMITS_READER_LOOP_EN
  logic stop_q, stop_d;
`endif

  // Handshake, FIFO and credit bookkeeping shared by the issue logic and the FSM.
  always_comb begin
    busy          = (state_q != StIdle) || done_q;
    // A start arriving during the done cycle still counts as "while busy" and is dropped.
    start_acc     = ctrl_start && (state_q == StIdle) && !done_q;
    fifo_nonempty = (occ_q != '0);
    fifo_push     = inflight_q[READ_LATENCY-1];
    fifo_pop      = fifo_nonempty && st_ready;
    head_last     = fifo_nonempty && (deliv_q == count_q - CntW'(1));
    // Reads on the bus, reads inside the RAM pipeline, and words already stored.
    credit        = CrW'(rd_q) + CrW'(occ_q);
    for (int i = 0; i < READ_LATENCY; i++) begin
      credit = credit + CrW'(inflight_q[i]);
    end
    // A pop this cycle frees a slot by the time the new read lands.
    room          = (credit - CrW'(fifo_pop)) < CrW'(FIFO_DEPTH);
    // Only the head word is outstanding, so this handshake closes the run.
    drain_exit    = fifo_pop && head_last && (credit == CrW'(1));
`ifdef LIMITS_READER_LOOP_EN
    stop_now      = stop_q;
`else
    stop_now      = 1'b1;
`endif
  end

  // Read issue: the start cycle uses the live control inputs so buf_read rises right after it.
  always_comb begin
    eff_base   = base_q;
    eff_count  = count_q;
    eff_issued = issued_q;
    in_run     = (state_q == StFetch);
    if (start_acc) begin
      eff_base   = ctrl_base;
      eff_count  = ctrl_count;
      eff_issued = '0;
      in_run     = 1'b1;
    end
    rd_d     = in_run && (eff_issued < eff_count) && room;
    addr_d   = addr_q;
    issued_d = eff_issued;
    if (rd_d) begin
      addr_d = eff_base + eff_issued[ADDR_W-1:0];
      // In loop mode the pass restarts at base without a bubble unless a stop is pending.
      if ((eff_issued == eff_count - CntW'(1)) && !stop_now) begin
        issued_d = '0;
      end else begin
        issued_d = eff_issued + CntW'(1);
      end
    end
    base_d  = eff_base;
    count_d = eff_count;
  end

  // Delivery counter, done pulse and stop latch.
  always_comb begin
    deliv_d = deliv_q;
    if (start_acc) begin
      deliv_d = '0;
    end else if (fifo_pop) begin
      deliv_d = head_last ? '0 : deliv_q + CntW'(1);
    end
    done_d = (start_acc && (ctrl_count == '0)) || (fifo_pop && head_last);
`ifdef LIMITS_READER_LOOP_EN
    stop_d = stop_q;
    if (start_acc) begin
      stop_d = 1'b0;
    end else if (ctrl_stop && busy) begin
      stop_d = 1'b1;
    end
`endif
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_acc && (ctrl_count != '0)) state_d = StFetch;
      StFetch: if (issued_q == count_q) state_d = StDrain;
      StDrain: if (drain_exit) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Run context, issue pipeline and FIFO pointers; reset also drops in-flight reads.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      base_q     <= '0;
      count_q    <= '0;
      issued_q   <= '0;
      deliv_q    <= '0;
      rd_q       <= 1'b0;
      addr_q     <= '0;
      inflight_q <= '0;
      done_q     <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      occ_q      <= '0;
    end else begin
      base_q        <= base_d;
      count_q       <= count_d;
      issued_q      <= issued_d;
      deliv_q       <= deliv_d;
      rd_q          <= rd_d;
      addr_q        <= addr_d;
      done_q        <= done_d;
      inflight_q[0] <= rd_q;
      for (int i = 1; i < READ_LATENCY; i++) begin
        inflight_q[i] <= inflight_q[i-1];
      end
      if (fifo_push) begin
        wptr_q <= (wptr_q == PtrW'(FIFO_DEPTH - 1)) ? '0 : wptr_q + PtrW'(1);
      end
      if (fifo_pop) begin
        rptr_q <= (rptr_q == PtrW'(FIFO_DEPTH - 1)) ? '0 : rptr_q + PtrW'(1);
      end
      occ_q <= occ_q + OccW'(fifo_push) - OccW'(fifo_pop);
    end
  end

`ifdef LIMITS_READER_LOOP_EN
  // Pending stop request.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stop_q <= 1'b0;
    end else begin
      stop_q <= stop_d;
    end
  end
`endif

  // FIFO storage; contents are don't-care while the matching slot is empty.
  always_ff @(posedge clock) begin
    if (fifo_push) begin
      fifo_mem[wptr_q] <= buf_readdata;
    end
  end

  // Outputs; st_data is forced to zero while the FIFO is empty.
  always_comb begin
    ctrl_busy      = busy;
    ctrl_done      = done_q;
    buf_address    = addr_q;
    buf_read       = rd_q;
    buf_chipselect = rd_q;
    st_valid       = fifo_nonempty;
    st_last        = head_last;
    st_data        = '0;
    if (fifo_nonempty) begin
      st_data = fifo_mem[rptr_q];
    end
  end

endmodule

// File: tb/tb_limits_reader.sv
// Self-checking bench for limits_reader: RAM model with two-cycle read latency,
// randomized runs and backpressure checked against a queue-based reference model.
module tb_limits_reader;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 4;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              ctrl_start = 1'b0;
  logic [ADDR_W-1:0] ctrl_base = '0;
  logic [ADDR_W:0]   ctrl_count = '0;
  logic              ctrl_stop = 1'b0;
  logic              ctrl_busy, ctrl_done;
  logic [ADDR_W-1:0] buf_address;
  logic              buf_chipselect, buf_read;
  logic [DATA_W-1:0] buf_readdata;
  logic [DATA_W-1:0] st_data;
  logic              st_valid, st_last;
  logic              st_ready = 1'b0;

  limits_reader dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .ctrl_start     (ctrl_start),
    .ctrl_base      (ctrl_base),
    .ctrl_count     (ctrl_count),
`ifdef LIMITS_READER_LOOP_EN
    .ctrl_stop      (ctrl_stop),
`endif
    .ctrl_busy      (ctrl_busy),
    .ctrl_done      (ctrl_done),
    .buf_address    (buf_address),
    .buf_chipselect (buf_chipselect),
    .buf_read       (buf_read),
    .buf_readdata   (buf_readdata),
    .st_data        (st_data),
    .st_valid       (st_valid),
    .st_ready       (st_ready),
    .st_last        (st_last)
  );

  always #5 clock = ~clock;

  // Buffer model: address registered, then output registered.
  logic [DATA_W-1:0] ram [256];
  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_rdata;
  always @(posedge clock) begin
    ram_addr_q <= buf_address;
    ram_rdata  <= ram[ram_addr_q];
  end
  assign buf_readdata = ram_rdata;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model state: expected words and addresses for the current run.
  logic [DATA_W-1:0] exp_q[$];
  logic [ADDR_W-1:0] exp_addr_q[$];
  int cyc = 0;
  int start_cyc;
  int reads, valids, hs, dones, busys;
  int first_read, last_read, first_valid, last_valid, last_hs, done_cyc, first_busy;
  int issued_tot = 0;
  int deliv_tot = 0;
  bit rand_ready = 0;
  bit hold_ready = 0;
  bit prev_stall = 0;
  logic [DATA_W-1:0] prev_data;

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: drives st_ready and checks every cycle at the falling edge.
  always @(negedge clock) begin
    logic rdy;
    if (!reset_n) begin
      prev_stall = 0;
      st_ready   = 1'b0;
    end else begin
      if (hold_ready) rdy = 1'b0;
      else if (rand_ready) rdy = 1'($urandom_range(0, 1));
      else rdy = 1'b1;
      st_ready = rdy;
      if (buf_read) begin
        reads++;
        issued_tot++;
        if (first_read < 0) first_read = cyc;
        last_read = cyc;
        check_eq("read_expected", exp_addr_q.size() > 0, 1);
        if (exp_addr_q.size() > 0) check_eq("addr", buf_address, exp_addr_q.pop_front());
        check_eq("chipselect", buf_chipselect, 1);
      end
      check_eq("credit_le_depth", (issued_tot - deliv_tot) <= DEPTH, 1);
      if (prev_stall) begin
        check_eq("valid_hold", st_valid, 1);
        check_eq("data_hold", st_data, prev_data);
      end
      if (st_valid) begin
        valids++;
        if (first_valid < 0) first_valid = cyc;
        last_valid = cyc;
      end
      if (st_valid && rdy) begin
        hs++;
        deliv_tot++;
        last_hs = cyc;
        check_eq("hs_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          check_eq("last", st_last, exp_q.size() == 1);
          check_eq("data", st_data, exp_q.pop_front());
        end
      end
      if (ctrl_done) begin
        dones++;
        done_cyc = cyc;
      end
      if (ctrl_busy) begin
        busys++;
        if (first_busy < 0) first_busy = cyc;
      end
      prev_stall = st_valid && !rdy;
      prev_data  = st_data;
    end
  end

  task automatic start_run(input logic [ADDR_W-1:0] base, input int count);
    logic [ADDR_W-1:0] a;
    @(negedge clock);
    reads = 0; valids = 0; hs = 0; dones = 0; busys = 0;
    first_read = -1; last_read = -1; first_valid = -1; last_valid = -1;
    last_hs = -1; done_cyc = -1; first_busy = -1;
    for (int i = 0; i < count; i++) begin
      a = base + ADDR_W'(i);
      exp_q.push_back(ram[a]);
      exp_addr_q.push_back(a);
    end
    ctrl_base  = base;
    ctrl_count = (ADDR_W + 1)'(count);
    ctrl_start = 1'b1;
    start_cyc  = cyc;
    @(negedge clock);
    ctrl_start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (dones == 0 && n < budget) begin
      @(negedge clock);
      n++;
    end
    check_eq("done_seen", dones > 0, 1);
    repeat (8) @(negedge clock);
  endtask

  task automatic check_run(input string tag, input int count);
    check_eq({tag, "_done_count"}, dones, 1);
    check_eq({tag, "_words"}, hs, count);
    check_eq({tag, "_reads"}, reads, count);
    check_eq({tag, "_left"}, exp_q.size(), 0);
    check_eq({tag, "_busy_first"}, first_busy, start_cyc + 1);
    check_eq({tag, "_busy_len"}, busys, done_cyc - start_cyc);
    if (count > 0) check_eq({tag, "_done_lat"}, done_cyc - last_hs, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = $urandom;

    // Reset state.
    repeat (3) @(negedge clock);
    #1;
    check_eq("rst_outputs",
             {ctrl_busy, ctrl_done, buf_read, buf_chipselect, st_valid, st_last}, 0);
    check_eq("rst_addr_data", {buf_address, st_data}, 0);
    @(negedge clock);
    reset_n = 1'b1;

    // Basic run with the sink always ready.
    for (int i = 0; i < 4; i++) ram[8'h10 + i] = 32'hA0A0_0000 + i;
    start_run(8'h10, 4);
    wait_done(100);
    check_run("basic", 4);
    // Edge E0 lands at start_cyc+1, so E3 shows at start_cyc+4.
    check_eq("basic_first_read", first_read - start_cyc, 1);
    check_eq("basic_read_span", last_read - first_read, 3);
    check_eq("basic_first_valid", first_valid - start_cyc, 4);
    check_eq("basic_valid_cnt", valids, 4);
    check_eq("basic_valid_span", last_valid - first_valid, 3);

    // Address wrap-around.
    start_run(8'hFE, 4);
    wait_done(100);
    check_run("wrap", 4);
    check_eq("wrap_read_span", last_read - first_read, 3);

    // Full-buffer run with random backpressure.
    rand_ready = 1;
    start_run(8'($urandom), 256);
    wait_done(3000);
    check_run("full", 256);

    // Zero-length run.
    rand_ready = 0;
    start_run(8'h33, 0);
    wait_done(50);
    check_run("zero", 0);
    check_eq("zero_done_cyc", done_cyc - start_cyc, 1);
    check_eq("zero_valids", valids, 0);

    // Start pulsed mid-run with a different base must be ignored.
    rand_ready = 1;
    start_run(8'h20, 12);
    repeat (3) @(negedge clock);
    ctrl_base  = 8'h80;
    ctrl_count = 9'd3;
    ctrl_start = 1'b1;
    @(negedge clock);
    ctrl_start = 1'b0;
    wait_done(500);
    check_run("restart_ignored", 12);

    // Random runs.
    for (int r = 0; r < 4; r++) begin
      int cnt;
      cnt = $urandom_range(1, 40);
      start_run(8'($urandom), cnt);
      wait_done(1000);
      check_run("rand", cnt);
    end

    // Reset while 2 reads are in flight and the FIFO holds 2 words.
    rand_ready = 0;
    hold_ready = 1;
    start_run(8'h30, 8);
    repeat (4) @(negedge clock);
    check_eq("pre_rst_valid", st_valid, 1);
    check_eq("pre_rst_reads", reads, 4);
    reset_n = 1'b0;
    #1;
    check_eq("midrst_outputs",
             {ctrl_busy, ctrl_done, buf_read, buf_chipselect, st_valid, st_last}, 0);
    check_eq("midrst_addr_data", {buf_address, st_data}, 0);
    exp_q.delete();
    exp_addr_q.delete();
    issued_tot = 0;
    deliv_tot  = 0;
    hold_ready = 0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    start_run(8'h40, 1);
    wait_done(100);
    check_run("post_rst", 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
